// File: rtl/brainfuck_pkg.sv
// Shared definitions for the brainfuck core and its pre-execution helpers.
//   - Instruction byte values for the bracket opcodes (also used by brainfuck_cpu).
//   - Error codes reported by brainfuck_jump_resolver.
//   - State encoding of the jump resolver sequencer.
package brainfuck_pkg;

   localparam logic [7:0] INST_JUMP_FWD  = 8'h5b;  // '['
   localparam logic [7:0] INST_JUMP_BACK = 8'h5d;  // ']'

   localparam logic [2:0] ERR_NONE            = 3'd0;
   localparam logic [2:0] ERR_UNMATCHED_CLOSE = 3'd1;
   localparam logic [2:0] ERR_UNMATCHED_OPEN  = 3'd2;
   localparam logic [2:0] ERR_STACK_OVERFLOW  = 3'd3;
   localparam logic [2:0] ERR_TARGET_OVERFLOW = 3'd4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SCAN  = 3'd1;
   localparam logic [2:0] ST_FIX   = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/brainfuck_bracket_stack.sv
// Synchronous LIFO holding the addresses of currently open '[' brackets.
// Ports:
//   clk, rst_i    clock, asynchronous active-low reset (stack pointer only)
//   clear         empty the stack on the next edge (wins over push/pop)
//   push, pop     push push_data / discard top on the next edge
//   push_data     address to push
//   top           combinational top-of-stack entry (valid when !empty)
//   full, empty   occupancy flags; full means 2^ADDR_WIDTH entries held
module brainfuck_bracket_stack #(
   parameter int DATA_WIDTH = 15,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic [DATA_WIDTH-1:0] top,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   sp;
   logic [ADDR_WIDTH-1:0] top_idx;

   // One extra pointer bit distinguishes full from empty.
   assign full    = sp[ADDR_WIDTH];
   assign empty   = (sp == '0);
   assign top_idx = sp[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
   assign top     = mem[top_idx];

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         sp <= '0;
      end else if (clear) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + (ADDR_WIDTH+1)'(1);
      end else if (pop && !empty) begin
         sp <= sp - (ADDR_WIDTH+1)'(1);
      end
   end

   // Storage carries no reset; only the pointer defines validity.
   always_ff @(posedge clk) begin
      if (push && !full && !clear) begin
         mem[sp[ADDR_WIDTH-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/brainfuck_jump_resolver.sv
// Pre-execution sequencer: scans program memory once and fills the jump-pointer
// memory with matched-bracket targets for brainfuck_cpu. Runs while the CPU is
// held in reset; the CPU is released with (rst_i & done).
// '[' at i gets target j+1 and ']' at j gets target i+1 (the CPU jumps after
// its pc has already been incremented).
// Optional build macro: JUMP_RESOLVER_CLEAR_EN -- when defined, every
// non-bracket byte also gets jumpptr[address] = 0 during the scan.
// Ports:
//   clk, rst_i          clock, asynchronous active-low reset
//   start               begin a scan (honoured only in IDLE, DONE, ERROR)
//   prog_size           program length in bytes
//   inst_addr           program read address
//   inst_load_data      program byte at inst_addr (combinational read)
//   jumpptr_addr        jump-memory write address
//   jumpptr_store_data  jump target to write
//   jumpptr_we          jump-memory write strobe
//   busy                scan in progress
//   done, error         terminal status, held until the next start
//   error_code          1 unmatched ']', 2 unmatched '[', 3 stack overflow,
//                       4 target overflow
//   error_addr          address of the offending bracket
module brainfuck_jump_resolver
   import brainfuck_pkg::*;
#(
   parameter int INST_ADDR_WIDTH  = 15,
   parameter int STACK_ADDR_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_i,
   input  logic                       start,
   input  logic [INST_ADDR_WIDTH:0]   prog_size,
   output logic [INST_ADDR_WIDTH-1:0] inst_addr,
   input  logic [7:0]                 inst_load_data,
   output logic [INST_ADDR_WIDTH-1:0] jumpptr_addr,
   output logic [INST_ADDR_WIDTH-1:0] jumpptr_store_data,
   output logic                       jumpptr_we,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [2:0]                 error_code,
   output logic [INST_ADDR_WIDTH-1:0] error_addr
);

   logic [2:0]                 state;
   // Scan address carries one extra bit so a full-size program cannot wrap.
   logic [INST_ADDR_WIDTH:0]   scan_addr;
   logic [INST_ADDR_WIDTH-1:0] scan_addr_lo;
   logic [INST_ADDR_WIDTH-1:0] match_addr;
   logic [INST_ADDR_WIDTH-1:0] stk_top;
   logic                       stk_full;
   logic                       stk_empty;
   logic                       stk_push;
   logic                       stk_pop;
   logic                       start_ok;
   logic                       in_range;
   logic                       is_open;
   logic                       is_close;
   logic                       at_max;
   logic                       scan_byte;

   assign scan_addr_lo = scan_addr[INST_ADDR_WIDTH-1:0];
   assign inst_addr    = scan_addr_lo;

   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
   assign in_range  = (scan_addr < prog_size);
   assign scan_byte = (state == ST_SCAN) && in_range;
   assign is_open   = (inst_load_data == INST_JUMP_FWD);
   assign is_close  = (inst_load_data == INST_JUMP_BACK);
   // A ']' at the last address would need target address+1 for its '['.
   assign at_max    = &scan_addr_lo;

   assign stk_push = scan_byte && is_open && !stk_full;
   assign stk_pop  = scan_byte && is_close && !stk_empty && !at_max;

   assign busy  = (state == ST_SCAN) || (state == ST_FIX);
   assign done  = (state == ST_DONE);
   assign error = (state == ST_ERROR);

   brainfuck_bracket_stack #(
      .DATA_WIDTH (INST_ADDR_WIDTH),
      .ADDR_WIDTH (STACK_ADDR_WIDTH)
   ) u_stack (
      .clk       (clk),
      .rst_i     (rst_i),
      .clear     (start_ok),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (scan_addr_lo),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // Write port: ']' cycle writes its own entry from the popped '[' address,
   // the following FIX cycle back-patches the '[' entry.
   always_comb begin
      jumpptr_we         = 1'b0;
      jumpptr_addr       = '0;
      jumpptr_store_data = '0;
      if (stk_pop) begin
         jumpptr_we         = 1'b1;
         jumpptr_addr       = scan_addr_lo;
         jumpptr_store_data = stk_top + INST_ADDR_WIDTH'(1);
      end else if (state == ST_FIX) begin
         jumpptr_we         = 1'b1;
         jumpptr_addr       = match_addr;
         jumpptr_store_data = scan_addr_lo + INST_ADDR_WIDTH'(1);
      end
`ifdef JUMP_RESOLVER_CLEAR_EN
      else if (scan_byte && !is_open && !is_close) begin
         jumpptr_we         = 1'b1;
         jumpptr_addr       = scan_addr_lo;
         jumpptr_store_data = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state      <= ST_IDLE;
         scan_addr  <= '0;
         error_code <= ERR_NONE;
         error_addr <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state      <= ST_SCAN;
                  scan_addr  <= '0;
                  error_code <= ERR_NONE;
                  error_addr <= '0;
               end
            end
            ST_SCAN: begin
               if (!in_range) begin
                  if (stk_empty) begin
                     state <= ST_DONE;
                  end else begin
                     state      <= ST_ERROR;
                     error_code <= ERR_UNMATCHED_OPEN;
                     error_addr <= stk_top;
                  end
               end else if (is_open) begin
                  if (stk_full) begin
                     state      <= ST_ERROR;
                     error_code <= ERR_STACK_OVERFLOW;
                     error_addr <= scan_addr_lo;
                  end else begin
                     scan_addr <= scan_addr + (INST_ADDR_WIDTH+1)'(1);
                  end
               end else if (is_close) begin
                  if (stk_empty) begin
                     state      <= ST_ERROR;
                     error_code <= ERR_UNMATCHED_CLOSE;
                     error_addr <= scan_addr_lo;
                  end else if (at_max) begin
                     state      <= ST_ERROR;
                     error_code <= ERR_TARGET_OVERFLOW;
                     error_addr <= scan_addr_lo;
                  end else begin
                     state <= ST_FIX;
                  end
               end else begin
                  scan_addr <= scan_addr + (INST_ADDR_WIDTH+1)'(1);
               end
            end
            ST_FIX: begin
               state     <= ST_SCAN;
               scan_addr <= scan_addr + (INST_ADDR_WIDTH+1)'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Popped '[' address, held for the FIX back-patch.
   always_ff @(posedge clk) begin
      if (stk_pop) begin
         match_addr <= stk_top;
      end
   end

endmodule

// File: tb/tb_brainfuck_jump_resolver.sv
// Bench for brainfuck_jump_resolver: two instances (default sizes, and a
// small one with 4-bit addresses and a 4-deep stack), shared program memory,
// directed programs plus random programs against a queue-based bracket model.
module tb_brainfuck_jump_resolver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a, start_b;
   logic [15:0] prog_size_a;
   logic [4:0]  prog_size_b;
   logic [14:0] inst_addr_a, jp_addr_a, jp_data_a, err_addr_a;
   logic [3:0]  inst_addr_b, jp_addr_b, jp_data_b, err_addr_b;
   logic [7:0]  inst_data_a, inst_data_b;
   logic        we_a, busy_a, done_a, error_a;
   logic        we_b, busy_b, done_b, error_b;
   logic [2:0]  code_a, code_b;

   logic [7:0]  prog [256];

   assign inst_data_a = (inst_addr_a < 15'd256) ? prog[inst_addr_a[7:0]] : 8'h00;
   assign inst_data_b = prog[{4'h0, inst_addr_b}];

   brainfuck_jump_resolver #(.INST_ADDR_WIDTH(15), .STACK_ADDR_WIDTH(8)) dut_a (
      .clk(clk), .rst_i(rst_n), .start(start_a), .prog_size(prog_size_a),
      .inst_addr(inst_addr_a), .inst_load_data(inst_data_a),
      .jumpptr_addr(jp_addr_a), .jumpptr_store_data(jp_data_a), .jumpptr_we(we_a),
      .busy(busy_a), .done(done_a), .error(error_a),
      .error_code(code_a), .error_addr(err_addr_a));

   brainfuck_jump_resolver #(.INST_ADDR_WIDTH(4), .STACK_ADDR_WIDTH(2)) dut_b (
      .clk(clk), .rst_i(rst_n), .start(start_b), .prog_size(prog_size_b),
      .inst_addr(inst_addr_b), .inst_load_data(inst_data_b),
      .jumpptr_addr(jp_addr_b), .jumpptr_store_data(jp_data_b), .jumpptr_we(we_b),
      .busy(busy_b), .done(done_b), .error(error_b),
      .error_code(code_b), .error_addr(err_addr_b));

   // Selected-instance view
   logic        sel;
   logic        m_we, m_busy, m_done, m_error;
   logic [2:0]  m_code;
   logic [31:0] m_jaddr, m_jdata, m_eaddr;
   always_comb begin
      if (sel) begin
         m_we = we_b; m_busy = busy_b; m_done = done_b; m_error = error_b; m_code = code_b;
         m_jaddr = 32'(jp_addr_b); m_jdata = 32'(jp_data_b); m_eaddr = 32'(err_addr_b);
      end else begin
         m_we = we_a; m_busy = busy_a; m_done = done_a; m_error = error_a; m_code = code_a;
         m_jaddr = 32'(jp_addr_a); m_jdata = 32'(jp_data_a); m_eaddr = 32'(err_addr_a);
      end
   end

   int    vectors = 0;
   int    miscompares = 0;
   string cur = "init";

   int exp_jp [256];
   bit exp_wr [256];
   int got_jp [256];
   bit got_wr [256];
   int exp_code, exp_eaddr, exp_k, exp_nwr;
   int wrcnt, badwr, edges;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s.%s: observed %0d, expected %0d", cur, tag, obs, exp);
      end
   endtask

   // Reference: walk the program with a plain queue as the bracket stack.
   task automatic model(input int size, input int depth, input int amax);
      int stk[$];
      int i;
      exp_code = 0; exp_eaddr = 0; exp_k = 0; exp_nwr = 0;
      for (int n = 0; n < 256; n++) begin exp_wr[n] = 0; exp_jp[n] = 0; end
      for (int a = 0; a < size; a++) begin
         if (prog[a] == 8'h5b) begin
            if (stk.size() == depth) begin exp_code = 3; exp_eaddr = a; return; end
            stk.push_back(a);
         end else if (prog[a] == 8'h5d) begin
            if (stk.size() == 0) begin exp_code = 1; exp_eaddr = a; return; end
            if (a == amax) begin exp_code = 4; exp_eaddr = a; return; end
            i = stk.pop_back();
            exp_jp[a] = i + 1; exp_wr[a] = 1;
            exp_jp[i] = a + 1; exp_wr[i] = 1;
            exp_k++; exp_nwr += 2;
         end else begin
`ifdef JUMP_RESOLVER_CLEAR_EN
            exp_jp[a] = 0; exp_wr[a] = 1; exp_nwr++;
`endif
         end
      end
      if (stk.size() != 0) begin exp_code = 2; exp_eaddr = stk[$]; end
   endtask

   // Record the write that the coming edge performs, then advance one edge.
   task automatic tick();
      if (m_we === 1'b1) begin
         wrcnt++;
         if (m_jaddr < 256) begin
            got_wr[m_jaddr] = 1;
            got_jp[m_jaddr] = int'(m_jdata);
         end else begin
            badwr++;
         end
      end
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic set_start(input bit v);
      if (sel) start_b = v; else start_a = v;
   endtask

   task automatic run(input bit s, input int size, input int hold);
      bit finished;
      int bad;
      sel = s;
      model(size, s ? 4 : 256, s ? 15 : 32767);
      for (int n = 0; n < 256; n++) begin got_wr[n] = 0; got_jp[n] = 0; end
      wrcnt = 0; badwr = 0; edges = 0; finished = 0;
      if (s) prog_size_b = 5'(size); else prog_size_a = 16'(size);
      set_start(1'b1);
      while (edges < 2 * size + 10) begin
         if (edges == hold) set_start(1'b0);
         tick();
         if (m_done === 1'b1 || m_error === 1'b1) begin finished = 1; break; end
      end
      set_start(1'b0);
      check("finished", 32'(finished), 32'd1);
      check("done", 32'(m_done), 32'(exp_code == 0));
      check("error", 32'(m_error), 32'(exp_code != 0));
      check("error_code", 32'(m_code), 32'(exp_code));
      check("error_addr", m_eaddr, 32'(exp_eaddr));
      check("busy_after", 32'(m_busy), 32'd0);
      if (exp_code == 0) check("done_edge", 32'(edges), 32'(size + exp_k + 2));
      bad = badwr;
      for (int n = 0; n < 256; n++) begin
         if (got_wr[n] != exp_wr[n]) bad++;
         else if (exp_wr[n] && got_jp[n] != exp_jp[n]) bad++;
      end
      check("jp_contents", 32'(bad), 32'd0);
      check("jp_writes", 32'(wrcnt), 32'(exp_nwr));
   endtask

   task automatic load(input string str);
      for (int a = 0; a < str.len(); a++) prog[a] = str[a];
   endtask

   task automatic gen(input int maxlen, output int len);
      logic [7:0] ops [6];
      int depth;
      int r;
      bit bal;
      ops = '{8'h2b, 8'h2d, 8'h3e, 8'h3c, 8'h2e, 8'h2c};
      depth = 0;
      bal = 1'($urandom_range(0, 1));
      len = $urandom_range(0, maxlen);
      for (int a = 0; a < len; a++) begin
         r = $urandom_range(0, 99);
         if (bal) begin
            if (len - a <= depth) begin prog[a] = 8'h5d; depth--; end
            else if (r < 30) begin prog[a] = 8'h5b; depth++; end
            else if (r < 55 && depth > 0) begin prog[a] = 8'h5d; depth--; end
            else prog[a] = ops[$urandom_range(0, 5)];
         end else begin
            if (r < 25) prog[a] = 8'h5b;
            else if (r < 50) prog[a] = 8'h5d;
            else prog[a] = ops[$urandom_range(0, 5)];
         end
      end
   endtask

   task automatic check_zero_a();
      check("busy", 32'(busy_a), 32'd0);
      check("done", 32'(done_a), 32'd0);
      check("error", 32'(error_a), 32'd0);
      check("error_code", 32'(code_a), 32'd0);
      check("error_addr", 32'(err_addr_a), 32'd0);
      check("inst_addr", 32'(inst_addr_a), 32'd0);
      check("we", 32'(we_a), 32'd0);
      check("jp_addr", 32'(jp_addr_a), 32'd0);
      check("jp_data", 32'(jp_data_a), 32'd0);
   endtask

   initial begin
      int len;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      prog_size_a = '0; prog_size_b = '0; sel = 1'b0;
      for (int n = 0; n < 256; n++) prog[n] = 8'h00;

      cur = "reset";
      repeat (3) @(posedge clk);
      #1;
      check_zero_a();
      check("b_busy", 32'(busy_b), 32'd0);
      check("b_done", 32'(done_b), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      cur = "loop3";
      load("[-]");
      run(0, 3, 1);
      check("jp2", 32'(got_jp[2]), 32'd1);
      check("jp0", 32'(got_jp[0]), 32'd3);
      check("edge", 32'(edges), 32'd6);

      cur = "nested";
      load("+[>[-]<]");
      run(0, 8, 1);
      check("jp5", 32'(got_jp[5]), 32'd4);
      check("jp3", 32'(got_jp[3]), 32'd6);
      check("jp7", 32'(got_jp[7]), 32'd2);
      check("jp1", 32'(got_jp[1]), 32'd8);
      check("edge", 32'(edges), 32'd12);

      cur = "close_only";
      load("]");
      run(0, 1, 1);
      check("code", 32'(code_a), 32'd1);
      check("nwr", 32'(wrcnt), 32'd0);

      cur = "open2";
      load("[[");
      run(0, 2, 1);
      check("code", 32'(code_a), 32'd2);
      check("eaddr", 32'(err_addr_a), 32'd1);

      cur = "stack_ovf";
      load("[[[[[");
      run(1, 5, 1);
      check("code", 32'(code_b), 32'd3);
      check("eaddr", 32'(err_addr_b), 32'd4);

      cur = "target_ovf";
      prog[0] = 8'h5b;
      for (int a = 1; a < 15; a++) prog[a] = 8'h2b;
      prog[15] = 8'h5d;
      run(1, 16, 1);
      check("code", 32'(code_b), 32'd4);
      check("eaddr", 32'(err_addr_b), 32'd15);

      cur = "mid_reset";
      sel = 1'b0;
      load("+[>[-]<]");
      prog_size_a = 16'd8;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (4) tick();
      check("busy_before", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check_zero_a();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      cur = "empty_prog";
      run(0, 0, 1);
      check("edge", 32'(edges), 32'd2);

      cur = "start_busy";
      load("[-]");
      run(0, 3, 3);
      check("edge", 32'(edges), 32'd6);

      for (int t = 0; t < 40; t++) begin
         cur = $sformatf("rand_a%0d", t);
         gen(48, len);
         run(0, len, 1);
      end
      for (int t = 0; t < 40; t++) begin
         cur = $sformatf("rand_b%0d", t);
         gen(16, len);
         run(1, len, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/brainfuck_jump_resolver.md
Name: brainfuck_jump_resolver

Overview:
- Pre-execution sequencer that scans program memory once and fills the jump-pointer memory with matched-bracket targets for brainfuck_cpu.
- Runs while the CPU is held in reset; the CPU is released with `rst_i & done`.
- Program-memory and jump-pointer-memory muxing between resolver and CPU is external.
- Validates bracket structure and reports the first error with its address.

Parameters:
- INST_ADDR_WIDTH, 15, instruction address width (matches CPU).
- STACK_ADDR_WIDTH, 8, log2 of bracket-stack depth (256 nesting levels).

Ports:
- clk  input  1  clock; rising edge advances state.
- rst_i  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled in IDLE, DONE or ERROR.
- prog_size  input  INST_ADDR_WIDTH+1  program length in bytes.
- inst_addr  output  INST_ADDR_WIDTH  program read address.
- inst_load_data  input  8  program byte; combinational read of inst_addr in the same cycle.
- jumpptr_addr  output  INST_ADDR_WIDTH  jump-memory write address.
- jumpptr_store_data  output  INST_ADDR_WIDTH  jump target to write.
- jumpptr_we  output  1  jump-memory write strobe; high = write this edge.
- busy  output  1  scan in progress.
- done  output  1  scan finished with no error; held until next start.
- error  output  1  scan aborted; held until next start.
- error_code  output  3  1 = unmatched ']', 2 = unmatched '[', 3 = stack overflow, 4 = target overflow.
- error_addr  output  INST_ADDR_WIDTH  address of the offending bracket.

Behaviour:
- Reset: state IDLE, stack pointer 0, scan address 0. All outputs 0.
- Reset mid-scan aborts the scan. Jump-memory contents are then undefined and a fresh start is required.
- States: IDLE, SCAN, FIX, DONE, ERROR.
- IDLE/DONE/ERROR with start=1:
  - Clear done, error, error_code and error_addr.
  - Set address to 0 and stack pointer to 0.
  - Go to SCAN.
- start is ignored in SCAN and FIX.
- busy = 1 exactly in SCAN and FIX.
- SCAN, address < prog_size, inst_addr = address:
  - '[' (8'h5b), stack full: go to ERROR, code 3, error_addr = address.
  - '[' otherwise: push address, address+1.
  - ']' (8'h5d), stack empty: go to ERROR, code 1, error_addr = address.
  - ']' with address = 2^INST_ADDR_WIDTH-1: go to ERROR, code 4, error_addr = address.
  - ']' otherwise: pop i into a holding register; write jumpptr[address] = i+1 this cycle; go to FIX, address unchanged.
  - Any other byte: address+1, no write.
- FIX: write jumpptr[i] = address+1; address+1; go to SCAN.
- SCAN with address >= prog_size:
  - Stack empty: go to DONE.
  - Stack non-empty: go to ERROR, code 2, error_addr = top-of-stack entry (innermost unmatched '[').
- Jump semantics (CPU jumps after its pc has already been incremented):
  - '[' at i targets j+1 (just past the matching ']').
  - ']' at j targets i+1 (just past the matching '[').
  - Targets are INST_ADDR_WIDTH bits.
- jumpptr_we is high only in the ']' SCAN cycle and in FIX. Address and data change registered or combinationally from state, stable while we is high.
- Latency: with N = prog_size and K = number of ']', done rises on the (N+K+2)th rising edge, counting the start-sampling edge as the first.
- prog_size = 0: done on the 2nd edge, no writes.
- Stack pointer is STACK_ADDR_WIDTH+1 bits; full means sp = 2^STACK_ADDR_WIDTH.

Optional Feature:
- JUMP_RESOLVER_CLEAR_EN:
  - Defined: every non-bracket byte in SCAN also writes jumpptr[address] = 0, giving deterministic memory contents; latency is unchanged.
  - Undefined: non-bracket entries are untouched.

Decomposition:
- Shared package brainfuck_pkg holds the instruction byte constants (shared with brainfuck_cpu), the error-code constants and the resolver state encoding.
- One sub-module, brainfuck_bracket_stack: synchronous LIFO with push, pop, top, full and empty, plus a clear input.

Test Plan:
- "[-]", size 3, start: writes jp[2]=1 then jp[0]=3; done on edge 6; error 0.
- "+[>[-]<]", size 8:
  - Writes jp[5]=4, jp[3]=6, jp[7]=2, jp[1]=8.
  - done on edge 12; busy low after.
- "]", size 1: error, code 1, error_addr 0; no jumpptr_we pulses.
- "[[", size 2: error, code 2, error_addr 1.
- STACK_ADDR_WIDTH=2, "[[[[[": error, code 3, error_addr 4.
- Assert rst_i low mid-scan of test 2:
  - All outputs 0 immediately (asynchronous).
  - Then start with prog_size 0 gives done on edge 2.
  - A start pulse during busy is ignored.
